// File: rtl/router_pkg.sv
// Shared router constants: VC encodings, default packet width and a width helper.
// Pure declarations; no latency, no backpressure involvement.
package router_pkg;

  localparam logic VC_EVEN = 1'b0;
  localparam logic VC_ODD  = 1'b1;

  localparam int DEFAULT_DATA_WIDTH = 64;

  // Bits needed to encode values 0..n-1 (0 for n<=1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/vc_output_port_if.sv
// Handshake bundle between the input interfaces / downstream link and one output port.
// master drives requests, phase and ready; slave (the port) drives grants and the link.
interface vc_output_port_if
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_IN     = 4
);

  logic                         polarity;
  logic [NUM_IN-1:0]            req;
  logic [NUM_IN*DATA_WIDTH-1:0] data_in;
  logic [NUM_IN-1:0]            clear;
  logic                         ro;
  logic                         so;
  logic [DATA_WIDTH-1:0]        data_out;
  logic [1:0]                   full_vc;
  logic                         empty;

  modport master (
    output polarity, req, data_in, ro,
    input  clear, so, data_out, full_vc, empty
  );

  modport slave (
    input  polarity, req, data_in, ro,
    output clear, so, data_out, full_vc, empty
  );

endinterface

// File: rtl/vc_fifo.sv
// One virtual-channel buffer: BUF_DEPTH entries, head/tail wrap at BUF_DEPTH-1, rdata shows head.
// Push is ignored when full and pop when empty; read data is combinational from the head entry.
module vc_fifo
  import router_pkg::*;
#(
  parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int  BUF_DEPTH  = 2,
  localparam int PW         = (BUF_DEPTH > 1) ? clog2(BUF_DEPTH) : 1,
  localparam int CW         = clog2(BUF_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count == CW'(BUF_DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[head];

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[tail] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= (tail == PW'(BUF_DEPTH - 1)) ? '0 : tail + 1'b1;
      if (pop_ok)  head <= (head == PW'(BUF_DEPTH - 1)) ? '0 : head + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/vc_output_port.sv
// Round-robin output port: writes VC[polarity], sends VC[~polarity]; so/data_out one edge after send.
// A full write VC blocks all requesters (clear stays 0); ro=0 holds the send VC untouched.
module vc_output_port
  import router_pkg::*;
#(
  parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int  NUM_IN     = 4,
  parameter int  BUF_DEPTH  = 2,
  localparam int IW         = clog2(NUM_IN),
  localparam int CW         = clog2(BUF_DEPTH + 1)
) (
  input logic              clk,
  input logic              reset,
  vc_output_port_if.slave  port
);

  logic                  wvc;
  logic                  svc;
  logic [IW-1:0]         rr_ptr;
  logic                  grant_vld;
  logic [IW-1:0]         grant_idx;
  int                    scan;
  logic                  write_en;
  logic                  send_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] vc_rdata [2];
  logic [CW-1:0]         vc_count [2];
  logic [1:0]            vc_full;
  logic [1:0]            vc_empty;
  logic                  so_q;
  logic [DATA_WIDTH-1:0] data_out_q;

  assign wvc = port.polarity ? VC_ODD : VC_EVEN;
  assign svc = ~wvc;

  // Cyclic priority scan starting at rr_ptr; first requester found wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan      = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      scan = int'(rr_ptr) + k;
      if (scan >= NUM_IN) scan = scan - NUM_IN;
      if (!grant_vld && port.req[IW'(scan)]) begin
        grant_vld = 1'b1;
        grant_idx = IW'(scan);
      end
    end
  end

  always_comb begin
    wdata = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx == IW'(i)) wdata = port.data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign write_en   = grant_vld && !vc_full[wvc];
  assign send_en    = !vc_empty[svc] && port.ro;
  assign port.clear = write_en ? (NUM_IN'(1) << grant_idx) : '0;

  for (genvar v = 0; v < 2; v++) begin : g_vc
    vc_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .BUF_DEPTH  (BUF_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (write_en && (wvc == 1'(v))),
      .pop   (send_en && (svc == 1'(v))),
      .wdata (wdata),
      .rdata (vc_rdata[v]),
      .count (vc_count[v]),
      .full  (vc_full[v]),
      .empty (vc_empty[v])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr     <= '0;
      so_q       <= 1'b0;
      data_out_q <= '0;
    end else begin
      if (write_en) rr_ptr <= (grant_idx == IW'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
      so_q <= send_en;
      if (send_en) data_out_q <= vc_rdata[svc];
    end
  end

  assign port.so       = so_q;
  assign port.data_out = data_out_q;
  assign port.full_vc  = vc_full;
  assign port.empty    = (vc_count[0] == '0) && (vc_count[1] == '0);

endmodule

// File: tb/tb_vc_output_port.sv
// Three ports (depth 4, 2, 3) share one stimulus; each scenario checks one of them
// against a per-VC scoreboard filled at grant time and drained on each so pulse.
module tb_vc_output_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        polarity;
  logic [3:0]  req;
  logic        ro;
  logic [63:0] din [4];
  logic [255:0] data_in;

  logic        so_w    [3];
  logic [63:0] dout_w  [3];
  logic [3:0]  clear_w [3];
  logic [1:0]  full_w  [3];
  logic        empty_w [3];

  int depth [3] = '{4, 2, 3};

  int n_cmp = 0;
  int n_bad = 0;

  int          mcount [2];
  logic [1:0]  mrr;
  logic [63:0] q0 [$];
  logic [63:0] q1 [$];
  logic [63:0] last_dout;
  bit          last_wrote;
  int          n_sent;

  always #5 clk = ~clk;

  assign data_in = {din[3], din[2], din[1], din[0]};

  vc_output_port_if #(.DATA_WIDTH(64), .NUM_IN(4)) bus [3] ();

  for (genvar i = 0; i < 3; i++) begin : g_dut
    vc_output_port #(
      .DATA_WIDTH (64),
      .NUM_IN     (4),
      .BUF_DEPTH  ((i == 0) ? 4 : ((i == 1) ? 2 : 3))
    ) dut (
      .clk   (clk),
      .reset (reset),
      .port  (bus[i])
    );
    assign bus[i].polarity = polarity;
    assign bus[i].req      = req;
    assign bus[i].data_in  = data_in;
    assign bus[i].ro       = ro;
    assign so_w[i]    = bus[i].so;
    assign dout_w[i]  = bus[i].data_out;
    assign clear_w[i] = bus[i].clear;
    assign full_w[i]  = bus[i].full_vc;
    assign empty_w[i] = bus[i].empty;
  end

  task automatic model_clear();
    mcount[0] = 0;
    mcount[1] = 0;
    mrr       = 2'd0;
    q0.delete();
    q1.delete();
    last_dout = 64'd0;
    last_wrote = 1'b0;
    n_sent    = 0;
  endtask

  // One clock cycle with inputs already applied: grant/status checked mid-cycle, link after the edge.
  task automatic step(input int d, input string tag);
    logic [3:0]  exp_clear;
    logic [1:0]  g;
    logic [1:0]  idx;
    logic [1:0]  exp_full;
    logic [63:0] exp_d;
    logic        wv;
    logic        sv;
    bit          wr;
    bit          snd;
    wv = polarity;
    sv = ~polarity;
    @(negedge clk);
    wr = 1'b0;
    g  = 2'd0;
    if (req != 4'd0 && mcount[wv] < depth[d]) begin
      for (int k = 0; k < 4; k++) begin
        idx = mrr + 2'(k);
        if (!wr && req[idx]) begin
          wr = 1'b1;
          g  = idx;
        end
      end
    end
    exp_clear = wr ? (4'b0001 << g) : 4'b0000;
    snd = (mcount[sv] > 0) && ro;
    exp_full = {mcount[1] == depth[d], mcount[0] == depth[d]};
    n_cmp++;
    if (clear_w[d] !== exp_clear) begin
      n_bad++;
      $display("FAIL %s clear: got %b want %b", tag, clear_w[d], exp_clear);
    end
    n_cmp++;
    if (full_w[d] !== exp_full) begin
      n_bad++;
      $display("FAIL %s full_vc: got %b want %b", tag, full_w[d], exp_full);
    end
    n_cmp++;
    if (empty_w[d] !== (mcount[0] == 0 && mcount[1] == 0)) begin
      n_bad++;
      $display("FAIL %s empty: got %b want %b", tag, empty_w[d], (mcount[0] == 0 && mcount[1] == 0));
    end
    @(posedge clk);
    #1;
    if (wr) begin
      if (wv) q1.push_back(din[g]);
      else    q0.push_back(din[g]);
      mcount[wv]++;
      mrr = g + 2'd1;
    end
    exp_d = last_dout;
    if (snd) begin
      mcount[sv]--;
      exp_d = sv ? q1.pop_front() : q0.pop_front();
      n_sent++;
    end
    n_cmp++;
    if (so_w[d] !== snd) begin
      n_bad++;
      $display("FAIL %s so: got %b want %b", tag, so_w[d], snd);
    end
    n_cmp++;
    if (dout_w[d] !== exp_d) begin
      n_bad++;
      $display("FAIL %s data_out: got %h want %h", tag, dout_w[d], exp_d);
    end
    last_dout  = exp_d;
    last_wrote = wr;
  endtask

  task automatic cyc(input int d, input logic pol, input logic [3:0] r, input logic rdy, input string tag);
    polarity = pol;
    req      = r;
    ro       = rdy;
    step(d, tag);
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    polarity = 1'b0;
    req      = 4'd0;
    ro       = 1'b0;
    for (int i = 0; i < 4; i++) din[i] = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_clear();
  endtask

  task automatic drain(input int d, input string tag);
    int budget;
    budget = 0;
    while ((mcount[0] + mcount[1]) > 0 && budget < 20) begin
      cyc(d, ~polarity, 4'd0, 1'b1, tag);
      budget++;
    end
    n_cmp++;
    if ((mcount[0] + mcount[1]) != 0) begin
      n_bad++;
      $display("FAIL %s drain timeout: left %0d want 0", tag, mcount[0] + mcount[1]);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (so_w[0] !== 1'b0 || dout_w[0] !== 64'd0 || empty_w[0] !== 1'b1 || full_w[0] !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_init: so=%b dout=%h empty=%b full=%b want 0/0/1/00",
               so_w[0], dout_w[0], empty_w[0], full_w[0]);
    end
    for (int i = 0; i < 3; i++) begin
      din[0] = 64'h100 + 64'(i);
      cyc(0, 1'b0, 4'b0001, 1'b0, "rst_fill");
      cyc(0, 1'b1, 4'b0000, (i == 0) ? 1'b1 : 1'b0, "rst_fill");
    end
    // Two packets still buffered and data_out non-zero: reset must wipe everything.
    reset = 1'b0;
    #3;
    n_cmp++;
    if (so_w[0] !== 1'b0 || dout_w[0] !== 64'd0 || empty_w[0] !== 1'b1 || full_w[0] !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_mid: so=%b dout=%h empty=%b full=%b want 0/0/1/00",
               so_w[0], dout_w[0], empty_w[0], full_w[0]);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_clear();
    for (int i = 0; i < 4; i++) cyc(0, 1'(i), 4'b0000, 1'b1, "rst_after");
    din[0] = 64'h5A5A;
    cyc(0, 1'b0, 4'b0001, 1'b1, "rst_fresh");
    cyc(0, 1'b1, 4'b0000, 1'b1, "rst_fresh");
    cyc(0, 1'b0, 4'b0000, 1'b1, "rst_fresh");
  endtask

  task automatic test_single();
    do_reset();
    din[0] = 64'hA5;
    cyc(0, 1'b0, 4'b0001, 1'b1, "single_wr");
    cyc(0, 1'b1, 4'b0000, 1'b1, "single_send");
    n_cmp++;
    if (so_w[0] !== 1'b1 || dout_w[0] !== 64'hA5) begin
      n_bad++;
      $display("FAIL single_out: so=%b dout=%h want 1/a5", so_w[0], dout_w[0]);
    end
    cyc(0, 1'b0, 4'b0000, 1'b1, "single_idle");
  endtask

  task automatic test_round_robin();
    do_reset();
    din[0] = 64'h11;
    din[1] = 64'h22;
    din[2] = 64'h33;
    din[3] = 64'h44;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1'b0, 4'b1111, 1'b0, "rr_wr");
      cyc(0, 1'b1, 4'b0000, 1'b0, "rr_gap");
    end
    n_cmp++;
    if (q0.size() != 4 || q0[0] !== 64'h11 || q0[3] !== 64'h44) begin
      n_bad++;
      $display("FAIL rr_order: queued %0d entries, want 4 in order 11,22,33,44", q0.size());
    end
    drain(0, "rr_drain");
  endtask

  task automatic test_full();
    do_reset();
    din[0] = 64'h11;
    cyc(1, 1'b0, 4'b0001, 1'b0, "full_wr");
    din[0] = 64'h22;
    cyc(1, 1'b1, 4'b0000, 1'b0, "full_gap");
    cyc(1, 1'b0, 4'b0001, 1'b0, "full_wr");
    din[0] = 64'h33;
    cyc(1, 1'b1, 4'b0000, 1'b0, "full_gap");
    cyc(1, 1'b0, 4'b0001, 1'b0, "full_block");
    n_cmp++;
    if (last_wrote) begin
      n_bad++;
      $display("FAIL full_block: model granted into a full VC, want no write");
    end
    cyc(1, 1'b1, 4'b0000, 1'b1, "full_send");
    cyc(1, 1'b0, 4'b0001, 1'b0, "full_regrant");
    n_cmp++;
    if (!last_wrote || clear_w[1] !== 4'b0000) begin
      n_bad++;
      $display("FAIL full_regrant: wrote=%0d want 1", last_wrote);
    end
    drain(1, "full_drain");
  endtask

  task automatic test_backpressure();
    do_reset();
    din[0] = 64'h77;
    cyc(0, 1'b1, 4'b0001, 1'b0, "bp_wr");
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1'b0, 4'b0000, 1'b0, "bp_hold");
      cyc(0, 1'b1, 4'b0000, 1'b0, "bp_gap");
    end
    n_sent = 0;
    cyc(0, 1'b0, 4'b0000, 1'b1, "bp_release");
    cyc(0, 1'b1, 4'b0000, 1'b1, "bp_after");
    cyc(0, 1'b0, 4'b0000, 1'b1, "bp_after");
    n_cmp++;
    if (n_sent != 1) begin
      n_bad++;
      $display("FAIL bp_pulses: sent %0d want 1", n_sent);
    end
  endtask

  task automatic test_polarity_hold();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      din[0] = 64'h200 + 64'(i);
      cyc(0, 1'b0, 4'b0001, 1'b1, "hold_wr");
    end
    for (int i = 0; i < 4; i++) cyc(0, 1'b1, 4'b0000, 1'b1, "hold_send");
    n_cmp++;
    if (n_sent != 3) begin
      n_bad++;
      $display("FAIL hold_count: sent %0d want 3", n_sent);
    end
  endtask

  task automatic test_wrap();
    int next;
    int budget;
    do_reset();
    next   = 1;
    budget = 0;
    while ((next <= 7 || (mcount[0] + mcount[1]) > 0) && budget < 80) begin
      din[0] = 64'(next);
      cyc(2, ~polarity, (next <= 7) ? 4'b0001 : 4'b0000, 1'($urandom_range(0, 1)), "wrap");
      if (last_wrote) next++;
      budget++;
    end
    n_cmp++;
    if (n_sent != 7 || next != 8) begin
      n_bad++;
      $display("FAIL wrap_total: sent %0d written %0d want 7/7", n_sent, next - 1);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_backpressure();
    test_polarity_hold();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
